// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared stopwatch state codes (IDLE/COUNT/PAUSE/LAP) and BCD digit width
package stopwatch_pkg;
  localparam int BCD_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, PAUSE = 2'd2, LAP = 2'd3} state_t;
endpackage

// File: rtl/pb_debounce_pulse.sv
// pb_debounce_pulse: 2-FF sync + DB_CYCLES debounce + rising-edge one-cycle pulse; ports clk, rst_n, pb (raw in), pulse (out)
module pb_debounce_pulse #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic pulse
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  logic s1, s2, db, db_d;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {s1, s2, db, db_d, pulse} <= '0;
      cnt <= '0;
    end else begin
      s1 <= pb;
      s2 <= s1;
      db_d <= db;
      pulse <= db & ~db_d;
      cnt <= (s2 != db && cnt != LAST) ? cnt + 1'b1 : '0;
      db <= (s2 != db && cnt == LAST) ? s2 : db;
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced start/lap buttons, 4-state FSM, tick prescaler, BCD time counter, lap freeze; ports clk, rst_n, pb_start, pb_lap -> count_enable, state_led, tick, lap_active, time_live, time_disp
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 1000000,
  parameter int DB_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pb_start,
  input  logic                      pb_lap,
  output logic                      count_enable,
  output logic [1:0]                state_led,
  output logic                      tick,
  output logic                      lap_active,
  output logic [BCD_W*DIGITS-1:0]   time_live,
  output logic [BCD_W*DIGITS-1:0]   time_disp
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
  state_t state, st_n;
  logic s_p, l_p, s, l, ce_n, c;
  logic [PW-1:0] pre, pre_n;
  logic [BCD_W*DIGITS-1:0] lap_q, inc;
  pb_debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_start (.clk(clk), .rst_n(rst_n), .pb(pb_start), .pulse(s_p));
  pb_debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_lap (.clk(clk), .rst_n(rst_n), .pb(pb_lap), .pulse(l_p));
  assign s = s_p;
  assign l = l_p & ~s_p;
  always_comb begin
    st_n = state;
    unique case (state)
      IDLE:  st_n = s ? COUNT : IDLE;
      COUNT: st_n = s ? PAUSE : l ? LAP : COUNT;
      LAP:   st_n = s ? PAUSE : l ? COUNT : LAP;
      PAUSE: st_n = s ? COUNT : l ? IDLE : PAUSE;
    endcase
    ce_n = st_n == COUNT || st_n == LAP;
    pre_n = (st_n == IDLE || state == IDLE) ? '0 : count_enable ? (pre == PLAST ? '0 : pre + 1'b1) : pre;
  end
  always_comb begin
    inc = time_live;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      inc[BCD_W*i +: BCD_W] = c ? (time_live[BCD_W*i +: BCD_W] == 4'd9 ? 4'd0 : time_live[BCD_W*i +: BCD_W] + 4'd1) : time_live[BCD_W*i +: BCD_W];
      c = c & (time_live[BCD_W*i +: BCD_W] == 4'd9);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pre <= '0;
      {tick, count_enable, lap_active} <= '0;
      time_live <= '0;
      lap_q <= '0;
    end else begin
      state <= st_n;
      pre <= pre_n;
      tick <= ce_n && pre_n == PLAST;
      count_enable <= ce_n;
      lap_active <= st_n == LAP;
      time_live <= (state == PAUSE && st_n == IDLE) ? '0 : tick ? inc : time_live;
      if (state == COUNT && st_n == LAP) lap_q <= time_live;
    end
  end
  assign state_led = state;
  assign time_disp = lap_active ? lap_q : time_live;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: vector table, corner sequences and random presses checked against an integer-time reference model
module tb_stopwatch_ctrl;
  localparam int DIGITS = 2, TD = 4, DB = 3;
  logic clk = 0, rst_n = 0, pb_start = 0, pb_lap = 0;
  logic count_enable, tick, lap_active;
  logic [1:0] state_led;
  logic [7:0] time_live, time_disp;
  stopwatch_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .pb_start(pb_start), .pb_lap(pb_lap),
    .count_enable(count_enable), .state_led(state_led), .tick(tick),
    .lap_active(lap_active), .time_live(time_live), .time_disp(time_disp));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0;
  int ms, phase, mtime, mlap;
  bit y1[2], y2[2], lvl[2], prev[2], p[2];
  int run[2];
  typedef struct {bit r; bit s; bit l; int n; logic [20:0] exp;} vec_t;
  vec_t tbl[13];
  function automatic logic [7:0] bcd(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  function automatic logic [20:0] pack(int st, bit ce, bit tk, bit la, logic [7:0] live, logic [7:0] disp);
    return {2'(st), ce, tk, la, live, disp};
  endfunction
  task automatic model_edge(bit r, bit rs, bit rl);
    bit s, l, raw[2];
    int t0;
    if (!r) begin
      ms = 0; phase = 0; mtime = 0; mlap = 0;
      for (int b = 0; b < 2; b++) begin
        y1[b] = 0; y2[b] = 0; lvl[b] = 0; prev[b] = 0; p[b] = 0; run[b] = 0;
      end
      return;
    end
    s = p[0];
    l = p[1] && !p[0];
    t0 = mtime;
    if (ms == 1 || ms == 3) begin
      if (phase == TD - 1) mtime = (mtime + 1) % 100;
      phase = (phase + 1) % TD;
    end
    case (ms)
      0: if (s) begin ms = 1; phase = 0; end
      1: if (s) ms = 2; else if (l) begin ms = 3; mlap = t0; end
      3: if (s) ms = 2; else if (l) ms = 1;
      default: if (s) ms = 1; else if (l) begin ms = 0; mtime = 0; phase = 0; end
    endcase
    raw[0] = rs;
    raw[1] = rl;
    for (int b = 0; b < 2; b++) begin
      p[b] = lvl[b] && !prev[b];
      prev[b] = lvl[b];
      run[b] = (y2[b] != lvl[b]) ? run[b] + 1 : 0;
      if (run[b] == DB) begin lvl[b] = y2[b]; run[b] = 0; end
      y2[b] = y1[b];
      y1[b] = raw[b];
    end
  endtask
  task automatic step(bit r, bit s, bit l);
    logic [20:0] g, e;
    bit ce;
    rst_n = r; pb_start = s; pb_lap = l;
    @(posedge clk);
    model_edge(r, s, l);
    #1;
    cyc++;
    ce = ms == 1 || ms == 3;
    g = {state_led, count_enable, tick, lap_active, time_live, time_disp};
    e = pack(ms, ce, ce && phase == TD - 1, ms == 3, bcd(mtime), ms == 3 ? bcd(mlap) : bcd(mtime));
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL model cyc=%0d got=%h exp=%h", cyc, g, e);
    end
  endtask
  task automatic chk(string name, logic [20:0] got, logic [20:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic logic [20:0] outs();
    return {state_led, count_enable, tick, lap_active, time_live, time_disp};
  endfunction
  task automatic press(int which, int hold);
    for (int i = 0; i < 16; i++) step(1, i < hold && which != 1, i < hold && which != 0);
  endtask
  task automatic idle_run(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask
  initial begin
    int act, gb, go, gl;
    bit rs, gli;
    tbl[0]  = '{0, 1, 0, 2,  pack(0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[1]  = '{0, 0, 1, 1,  pack(0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[2]  = '{1, 0, 0, 5,  pack(0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[3]  = '{1, 1, 0, 5,  pack(0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[4]  = '{1, 1, 0, 1,  pack(0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[5]  = '{1, 1, 0, 1,  pack(1, 1, 0, 0, 8'h00, 8'h00)};
    tbl[6]  = '{1, 0, 0, 40, pack(1, 1, 0, 0, 8'h10, 8'h10)};
    tbl[7]  = '{1, 0, 0, 3,  pack(1, 1, 1, 0, 8'h10, 8'h10)};
    tbl[8]  = '{1, 0, 0, 1,  pack(1, 1, 0, 0, 8'h11, 8'h11)};
    tbl[9]  = '{1, 0, 1, 6,  pack(1, 1, 0, 0, 8'h12, 8'h12)};
    tbl[10] = '{1, 0, 1, 1,  pack(3, 1, 1, 1, 8'h12, 8'h12)};
    tbl[11] = '{1, 0, 0, 20, pack(3, 1, 1, 1, 8'h17, 8'h12)};
    tbl[12] = '{1, 0, 1, 7,  pack(1, 1, 0, 0, 8'h19, 8'h19)};
    for (int k = 0; k < 13; k++) begin
      for (int i = 0; i < tbl[k].n; i++) step(tbl[k].r, tbl[k].s, tbl[k].l);
      chk($sformatf("vec%0d", k), outs(), tbl[k].exp);
    end
    step(0, 0, 0);
    chk("reset_mid_count", outs(), 21'd0);
    idle_run(3);
    for (int i = 0; i < 16; i++) step(1, i inside {0, 2, 3, 6, 8, 9}, 0);
    chk("bounce_idle", 21'(state_led), 21'd0);
    press(0, 6);
    chk("start_after_bounce", 21'(state_led), 21'd1);
    idle_run(383);
    chk("at_98", 21'(time_live), 21'(8'h98));
    idle_run(8);
    chk("wrap_00", 21'(time_live), 21'(8'h00));
    press(0, 6);
    chk("pause_state", 21'(state_led), 21'd2);
    chk("pause_time", 21'(time_live), 21'(8'h01));
    idle_run(20);
    chk("pause_frozen", 21'(time_live), 21'(8'h01));
    press(1, 6);
    chk("clear_idle", outs(), 21'd0);
    press(0, 6);
    idle_run(5);
    press(2, 6);
    chk("simul_pause", 21'({state_led, lap_active}), 21'({2'd2, 1'b0}));
    for (int k = 0; k < 150; k++) begin
      act = $urandom_range(0, 5);
      gb = $urandom_range(0, 1);
      go = $urandom_range(0, 8);
      gl = $urandom_range(1, 2);
      rs = act == 5 && $urandom_range(0, 3) == 0;
      for (int i = 0; i < 16; i++) begin
        gli = act == 4 && i >= go && i < go + gl;
        step(!(rs && i == 0), ((act == 1 || act == 3) && i < 6) || (gli && gb == 0),
             ((act == 2 || act == 3) && i < 6) || (gli && gb == 1));
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
